br_resolve: RTL
===============

// Module: br_resolve
// PURPOSE
//  EX-stage branch resolver: checks BTB predictions against resolved MIPS branch outcomes.
//  ID pushes per-branch predictions into an in-order queue; EX pops one entry per resolved branch.
//  On a misprediction it drives br_bus {br_e, br_target} plus delayslot_pc back to the predictor/fetch.
//  A redirect is held until the delay-slot instruction has issued.
// PARAMETERS
//  PQ_DEPTH   4   prediction-queue entries (power of 2, >=2)
//  PQ_AW      2   log2(PQ_DEPTH)
// PORTS
//  clk            in   1   clock
//  resetn         in   1   synchronous active-low reset
//  stall          in   1   pipeline stall; gates queue push/pop and resolve sampling
//  id_br_valid    in   1   branch/jump instruction leaving ID this cycle
//  id_bp_bus      in   33  {bp_id_e, bp_id_target} prediction travelling with that branch
//  ex_br_valid    in   1   branch resolved in EX this cycle
//  ex_pc          in   32  PC of resolved branch
//  ex_taken       in   1   actual direction
//  ex_target      in   32  actual taken target
//  ds_valid       in   1   delay-slot instruction of the pending branch issued
//  pq_full        out  1   queue full; ID must stall pushes
//  br_bus         out  33  {br_e, br_target}; br_e is a 1-cycle redirect pulse
//  delayslot_pc   out  32  ex_pc+4 of the redirecting branch, valid with br_e
//  perf_branches  out  32  resolved-branch count
//  perf_mispred   out  32  redirect count
// BEHAVIOUR
//  Reset: queue empty, FSM IDLE, br_e=0, br_target=0, delayslot_pc=0, counters=0, pq_full=0.
//  Push: id_br_valid & !stall & (!full | pop same cycle). Pop: ex_br_valid & !stall & FSM==IDLE.
//  Push+pop in the same cycle when full is legal; count is unchanged.
//  Pop when empty: entry is treated as {0, 32'b0}, i.e. not predicted.
//  Pointers wrap modulo PQ_DEPTH. The count register is PQ_AW+1 bits.
//  Mispredict rules (p = popped entry):
//   p.e & ex_taken & p.target==ex_target   -> correct, no redirect
//   p.e & !ex_taken                        -> redirect to ex_pc+8
//   p.e & ex_taken & target mismatch       -> redirect to ex_target
//   !p.e & ex_taken                        -> redirect to ex_target
//   !p.e & !ex_taken                       -> correct
//  Address arithmetic is 32-bit modulo; wrap is ignored.
//  FSM IDLE: on a mispredict, latch tgt and dspc=ex_pc+4.
//   If ds_valid is also set -> REDIRECT, else -> WAIT_DS.
//  FSM WAIT_DS: ex_br_valid is ignored (wrong path). On ds_valid -> REDIRECT.
//  FSM REDIRECT: br_e=1 for exactly one cycle with br_target=tgt and delayslot_pc=dspc.
//   The queue is flushed (empty) in the same cycle; then -> IDLE.
//  Latency: br_e is registered, asserted the cycle after resolve when ds_valid arrives with the resolve.
//  Stall: freezes push/pop/resolve. WAIT_DS->REDIRECT and the REDIRECT pulse proceed regardless of stall.
//  A push arriving in the REDIRECT cycle is discarded; it is wrong path.
//  Reset mid-WAIT_DS or mid-REDIRECT: returns to IDLE, no br_e emitted.
//  br_e and br_target drop to 0 in every non-REDIRECT cycle.
// CONFIGURATION
//  BR_PERF_CNT_EN defined: perf_branches +1 per pop, perf_mispred +1 per REDIRECT.
//   Both are 32-bit and wrap at 2^32.
//  BR_PERF_CNT_EN undefined: both ports tied to 32'b0, no counter flops.
// TESTING
//  1 Reset: hold resetn=0 for 2 cycles -> br_e=0, pq_full=0, delayslot_pc=0.
//  2 Correct prediction: push {1,0xBFC00100}; resolve ex_pc=0xBFC00040, taken, target 0xBFC00100,
//    ds_valid=1 -> no br_e, queue empty.
//  3 False taken: push {1,0xBFC00100}; resolve ex_pc=0xBFC00040, not taken, ds_valid=1
//    -> next cycle br_bus={1,0xBFC00048}, delayslot_pc=0xBFC00044.
//  4 Late delay slot: push {0,0}; resolve taken, target 0x80001000, ds_valid=0 for 3 cycles, then 1;
//    extra ex_br_valid while waiting -> single br_e carrying 0x80001000, one cycle after ds_valid.
//  5 Queue full: 4 pushes -> pq_full=1; push+pop same cycle -> count stays 4;
//    pop on empty -> handled as unpredicted.
//  6 Reset in WAIT_DS, and stall=1 during REDIRECT -> no br_e after reset; the pulse still fires
//    under stall. With BR_PERF_CNT_EN: 3 resolves, 1 mispredict -> perf_branches=3, perf_mispred=1.

Source files
------------

// File: rtl/br_resolve.sv
// br_resolve: EX-stage branch resolver comparing queued BTB predictions against resolved outcomes.
// Optional perf counters are enabled by defining BR_PERF_CNT_EN.
module br_resolve #(
    parameter int PQ_DEPTH = 4,
    parameter int PQ_AW    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        id_br_valid,
    input  logic [32:0] id_bp_bus,
    input  logic        ex_br_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ds_valid,
    output logic        pq_full,
    output logic [32:0] br_bus,
    output logic [31:0] delayslot_pc,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispred
);
    typedef enum logic [1:0] {IDLE, WAIT_DS, REDIRECT} state_t;
    state_t state;
    logic pq_e [PQ_DEPTH];
    logic [31:0] pq_tgt [PQ_DEPTH];
    logic [PQ_AW-1:0] wptr, rptr;
    logic [PQ_AW:0] cnt;
    logic [31:0] tgt, dspc, br_target, p_tgt, m_tgt;
    logic br_e, empty, pop, deq, push, p_e, mispred;
    assign empty   = cnt == '0;
    assign pq_full = cnt == (PQ_AW+1)'(PQ_DEPTH);
    assign pop     = ex_br_valid & ~stall & (state == IDLE);
    assign deq     = pop & ~empty;
    // Pushes during the redirect cycle belong to the wrong path and are dropped.
    assign push    = id_br_valid & ~stall & (~pq_full | pop) & (state != REDIRECT);
    assign p_e     = ~empty & pq_e[rptr];
    assign p_tgt   = empty ? 32'b0 : pq_tgt[rptr];
    assign mispred = p_e ? (~ex_taken | (p_tgt != ex_target)) : ex_taken;
    assign m_tgt   = (p_e & ~ex_taken) ? ex_pc + 32'd8 : ex_target;
    assign br_bus  = {br_e, br_target};
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            wptr         <= '0;
            rptr         <= '0;
            cnt          <= '0;
            tgt          <= '0;
            dspc         <= '0;
            br_e         <= 1'b0;
            br_target    <= '0;
            delayslot_pc <= '0;
        end else begin
            br_e      <= 1'b0;
            br_target <= '0;
            case (state)
                IDLE: if (pop & mispred) begin
                    tgt   <= m_tgt;
                    dspc  <= ex_pc + 32'd4;
                    state <= ds_valid ? REDIRECT : WAIT_DS;
                    if (ds_valid) begin
                        br_e         <= 1'b1;
                        br_target    <= m_tgt;
                        delayslot_pc <= ex_pc + 32'd4;
                    end
                end
                WAIT_DS: if (ds_valid) begin
                    state        <= REDIRECT;
                    br_e         <= 1'b1;
                    br_target    <= tgt;
                    delayslot_pc <= dspc;
                end
                default: state <= IDLE;
            endcase
            if (state == REDIRECT) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push) begin
                    pq_e[wptr]   <= id_bp_bus[32];
                    pq_tgt[wptr] <= id_bp_bus[31:0];
                    wptr         <= wptr + 1'b1;
                end
                if (deq) rptr <= rptr + 1'b1;
                cnt <= cnt + (PQ_AW+1)'(push) - (PQ_AW+1)'(deq);
            end
        end
    end
`ifdef BR_PERF_CNT_EN
    logic [31:0] n_br, n_mp;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            n_br <= '0;
            n_mp <= '0;
        end else begin
            if (pop) n_br <= n_br + 32'd1;
            if (state == REDIRECT) n_mp <= n_mp + 32'd1;
        end
    end
    assign perf_branches = n_br;
    assign perf_mispred  = n_mp;
`else
    assign perf_branches = 32'b0;
    assign perf_mispred  = 32'b0;
`endif
endmodule
